// File: rtl/sram_like_arbiter_pkg.sv
// ============================================================================
// Module      : sram_like_arbiter_pkg
// Description : Shared definitions for the SRAM-like two-master arbiter.
//               Provides the master ID encodings, the transfer size
//               encodings, the default outstanding depth and the bundled
//               address-phase request type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_like_arbiter_pkg;

  // Master IDs stored in the in-order ID FIFO
  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  // Transfer size encodings on *_size
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Default number of accepted-but-unanswered requests
  localparam int OUTSTANDING_DEFAULT = 4;

  // One master's complete address-phase request
  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } arb_req_t;

endpackage : sram_like_arbiter_pkg

`default_nettype wire

// File: rtl/sram_like_arbiter_id_fifo.sv
// ============================================================================
// Module      : arb_id_fifo
// Description : In-order FIFO of 1-bit master IDs, one entry per accepted
//               request. The head tells which master owns the next slave
//               response.
// Ports       : clk, resetn (async active-low)
//               push/push_id  - enqueue ID of an accepted request
//               pop           - dequeue head on a slave response
//               full/empty    - occupancy flags
//               head          - ID of oldest outstanding request
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_id_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  // Guards keep the pointers consistent even if a caller misbehaves;
  // the arbiter itself never pushes at full or pops when empty.
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_id;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule : arb_id_fifo

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// Module      : sram_like_arbiter
// Description : Two-to-one arbiter sharing one SRAM-like slave port between
//               the instruction-fetch master (inst_*) and the data master
//               (data_*). One address phase is granted per cycle, the grant
//               is held until mem_addr_ok, and an in-order ID FIFO routes
//               each mem_data_ok/mem_rdata back to the owning master.
// Config      : `define ARB_ROUND_ROBIN_EN to alternate between masters on
//               simultaneous requests; otherwise data has fixed priority.
// Ports       : clk, resetn (async assert, released through a 2-flop sync)
//               inst_* / data_*  - master request and response interfaces
//               mem_*            - shared slave port
//               protocol_err     - sticky: response with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction-fetch master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared slave port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        protocol_err
);

  // --------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge. The synchronised
  // reset also gates every output so they drop the instant resetn falls.
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  arb_req_t w_inst;
  arb_req_t w_data;
  arb_req_t w_sel;

  logic r_lock;
  logic r_lock_id;
  logic w_grant_valid;
  logic w_grant_id;
  logic w_accept;

  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_fifo_head;
  logic w_pop;

  assign w_inst = '{req: inst_req, wr: inst_wr, size: inst_size,
                    addr: inst_addr, wstrb: inst_wstrb, wdata: inst_wdata};
  assign w_data = '{req: data_req, wr: data_wr, size: data_size,
                    addr: data_addr, wstrb: data_wstrb, wdata: data_wdata};

`ifdef ARB_ROUND_ROBIN_EN
  // Master granted at the most recent accepted handshake.
  logic r_rr_last;
`endif

  // A lock is only ever taken on a grant that passed the full check, and
  // nothing can be pushed while it is held, so a locked grant skips that
  // check: its FIFO slot is already reserved.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = ARB_ID_DATA;
    if (w_rst_n) begin
      if (r_lock) begin
        w_grant_valid = 1'b1;
        w_grant_id    = r_lock_id;
      end else if (!w_fifo_full) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req && data_req) begin
          w_grant_valid = 1'b1;
          w_grant_id    = ~r_rr_last;
        end else if (data_req) begin
          w_grant_valid = 1'b1;
          w_grant_id    = ARB_ID_DATA;
        end else if (inst_req) begin
          w_grant_valid = 1'b1;
          w_grant_id    = ARB_ID_INST;
        end
`else
        // Data first: stalling fetch costs less than stalling a load/store.
        if (data_req) begin
          w_grant_valid = 1'b1;
          w_grant_id    = ARB_ID_DATA;
        end else if (inst_req) begin
          w_grant_valid = 1'b1;
          w_grant_id    = ARB_ID_INST;
        end
`endif
      end
    end
  end

  assign w_sel = (w_grant_id == ARB_ID_DATA) ? w_data : w_inst;

  assign mem_req   = w_grant_valid & w_sel.req;
  assign mem_wr    = w_grant_valid & w_sel.wr;
  assign mem_size  = w_grant_valid ? w_sel.size  : '0;
  assign mem_addr  = w_grant_valid ? w_sel.addr  : '0;
  assign mem_wstrb = w_grant_valid ? w_sel.wstrb : '0;
  assign mem_wdata = w_grant_valid ? w_sel.wdata : '0;

  assign w_accept     = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_accept & (w_grant_id == ARB_ID_INST);
  assign data_addr_ok = w_accept & (w_grant_id == ARB_ID_DATA);

  // --------------------------------------------------------------------------
  // Lock and round-robin state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_lock    <= 1'b0;
      r_lock_id <= ARB_ID_INST;
    end else if (w_accept) begin
      r_lock <= 1'b0;
    end else if (mem_req) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_grant_id;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset value "data" makes inst win the first simultaneous request.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rr_last <= ARB_ID_DATA;
    end else if (w_accept) begin
      r_rr_last <= w_grant_id;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Response routing
  // --------------------------------------------------------------------------
  arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (w_rst_n),
    .push    (w_accept),
    .push_id (w_grant_id),
    .pop     (w_pop),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .head    (w_fifo_head)
  );

  assign w_pop        = w_rst_n & mem_data_ok & ~w_fifo_empty;
  assign inst_data_ok = w_pop & (w_fifo_head == ARB_ID_INST);
  assign data_data_ok = w_pop & (w_fifo_head == ARB_ID_DATA);
  assign inst_rdata   = w_rst_n ? mem_rdata : '0;
  assign data_rdata   = w_rst_n ? mem_rdata : '0;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      protocol_err <= 1'b0;
    end else if (mem_data_ok && w_fifo_empty) begin
      protocol_err <= 1'b1;
    end
  end

endmodule : sram_like_arbiter

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// Module      : tb_sram_like_arbiter
// Description : Directed self-checking bench for sram_like_arbiter.
//               Inputs change 1 ns after the rising edge; combinational
//               outputs are compared 1 ns later, well before the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        protocol_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_like_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wstrb   (inst_wstrb),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .protocol_err (protocol_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0;
    inst_wstrb = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0;
    data_wstrb = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    resetn = 0;
    cyc(); cyc();
    resetn = 1;
    // two-flop release plus margin
    cyc(); cyc(); cyc();
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    inst_req = 1; inst_addr = 32'h1234_5678; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check_eq("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_addr",  mem_addr, 32'd0);
    check_eq("rst_inst_rdata", inst_rdata, 32'd0);
    check_eq("rst_perr",      {31'd0, protocol_err}, 32'd0);
    idle_inputs();
    do_reset();

    // ---- single inst read, response three cycles later ----
    inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2'd2; mem_addr_ok = 1;
    #1;
    check_eq("t1_mem_req",  {31'd0, mem_req}, 32'd1);
    check_eq("t1_mem_addr", mem_addr, 32'h1C00_0000);
    check_eq("t1_inst_aok", {31'd0, inst_addr_ok}, 32'd1);
    check_eq("t1_data_aok", {31'd0, data_addr_ok}, 32'd0);
    cyc(); inst_req = 0; mem_addr_ok = 0;
    cyc(); cyc();
    mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
    #1;
    check_eq("t1_inst_dok",   {31'd0, inst_data_ok}, 32'd1);
    check_eq("t1_inst_rdata", inst_rdata, 32'h0280_0C0C);
    check_eq("t1_data_dok",   {31'd0, data_data_ok}, 32'd0);
    cyc(); mem_data_ok = 0;

    // ---- simultaneous requests, slave stalls two cycles ----
    inst_req = 1; inst_addr = 32'h0000_0100;
    data_req = 1; data_addr = 32'h0000_0200; data_wr = 1;
    data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("t2_c0_addr", mem_addr, 32'h0000_0200);
    check_eq("t2_c0_wr",   {31'd0, mem_wr}, 32'd1);
    check_eq("t2_c0_iaok", {31'd0, inst_addr_ok}, 32'd0);
    cyc(); #1;
    check_eq("t2_c1_addr", mem_addr, 32'h0000_0200);
    cyc(); mem_addr_ok = 1; #1;
    check_eq("t2_c2_addr",  mem_addr, 32'h0000_0200);
    check_eq("t2_c2_wdata", mem_wdata, 32'hDEAD_BEEF);
    check_eq("t2_c2_daok",  {31'd0, data_addr_ok}, 32'd1);
    check_eq("t2_c2_iaok",  {31'd0, inst_addr_ok}, 32'd0);
    cyc(); data_req = 0; data_wr = 0; #1;
    check_eq("t2_c3_addr", mem_addr, 32'h0000_0100);
    check_eq("t2_c3_iaok", {31'd0, inst_addr_ok}, 32'd1);
    cyc(); inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'h11; #1;
    check_eq("t2_r0_ddok", {31'd0, data_data_ok}, 32'd1);
    check_eq("t2_r0_idok", {31'd0, inst_data_ok}, 32'd0);
    cyc(); mem_rdata = 32'h22; #1;
    check_eq("t2_r1_idok", {31'd0, inst_data_ok}, 32'd1);
    check_eq("t2_r1_ddok", {31'd0, data_data_ok}, 32'd0);
    cyc(); mem_data_ok = 0;

    // ---- lock holds inst even when data arrives later ----
    inst_req = 1; inst_addr = 32'h0000_0300;
    cyc(); data_req = 1; data_addr = 32'h0000_0400; #1;
    check_eq("t3_lock_addr", mem_addr, 32'h0000_0300);
    check_eq("t3_lock_daok", {31'd0, data_addr_ok}, 32'd0);
    mem_addr_ok = 1; #1;
    check_eq("t3_lock_iaok", {31'd0, inst_addr_ok}, 32'd1);
    cyc(); inst_req = 0; #1;
    check_eq("t3_data_aok", {31'd0, data_addr_ok}, 32'd1);
    // last accept is data; next simultaneous request
    cyc(); inst_req = 1; inst_addr = 32'h0000_0500;
    data_req = 1; data_addr = 32'h0000_0600; #1;
`ifdef ARB_ROUND_ROBIN_EN
    check_eq("t3_arb_addr", mem_addr, 32'h0000_0500);
`else
    check_eq("t3_arb_addr", mem_addr, 32'h0000_0600);
`endif
    cyc(); inst_req = 0; data_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1;
    cyc(); cyc(); cyc(); mem_data_ok = 0;

    // ---- FIFO full blocks a fifth request ----
    mem_addr_ok = 1; inst_req = 1;
    for (int k = 0; k < 4; k++) begin
      inst_addr = 32'h0000_1000 + 32'(4 * k);
      #1;
      check_eq("t4_fill_aok", {31'd0, inst_addr_ok}, 32'd1);
      cyc();
    end
    inst_addr = 32'h0000_2000; mem_data_ok = 1; mem_rdata = 32'h55; #1;
    check_eq("t4_full_req",  {31'd0, mem_req}, 32'd0);
    check_eq("t4_full_idok", {31'd0, inst_data_ok}, 32'd1);
    cyc(); mem_data_ok = 0; #1;
    check_eq("t4_unblk_req", {31'd0, mem_req}, 32'd1);
    check_eq("t4_unblk_aok", {31'd0, inst_addr_ok}, 32'd1);
    cyc(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("t4_drain_idok", {31'd0, inst_data_ok}, 32'd1);
      cyc();
    end
    mem_data_ok = 0;

    // ---- interleaved inst, data, inst ----
    mem_addr_ok = 1;
    inst_req = 1; inst_addr = 32'h0000_3000; cyc();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_3004; cyc();
    data_req = 0; inst_req = 1; inst_addr = 32'h0000_3008; cyc();
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'hA; #1;
    check_eq("t5_r0_idok", {31'd0, inst_data_ok}, 32'd1);
    check_eq("t5_r0_ddok", {31'd0, data_data_ok}, 32'd0);
    check_eq("t5_r0_data", inst_rdata, 32'hA);
    cyc(); mem_rdata = 32'hB; #1;
    check_eq("t5_r1_ddok", {31'd0, data_data_ok}, 32'd1);
    check_eq("t5_r1_idok", {31'd0, inst_data_ok}, 32'd0);
    check_eq("t5_r1_data", data_rdata, 32'hB);
    cyc(); mem_rdata = 32'hC; #1;
    check_eq("t5_r2_idok", {31'd0, inst_data_ok}, 32'd1);
    check_eq("t5_r2_data", inst_rdata, 32'hC);
    cyc();

    // ---- response with nothing outstanding ----
    #1;
    check_eq("t6_perr_pre", {31'd0, protocol_err}, 32'd0);
    check_eq("t6_idok", {31'd0, inst_data_ok}, 32'd0);
    check_eq("t6_ddok", {31'd0, data_data_ok}, 32'd0);
    cyc(); mem_data_ok = 0; #1;
    check_eq("t6_perr", {31'd0, protocol_err}, 32'd1);
    cyc(); #1;
    check_eq("t6_perr_sticky", {31'd0, protocol_err}, 32'd1);

    // ---- reset in the middle of traffic ----
    inst_req = 1; inst_addr = 32'h0000_4000; mem_addr_ok = 1;
    cyc();
    data_req = 1; data_addr = 32'h0000_4004;
    resetn = 0; #1;
    check_eq("t7_mem_req",  {31'd0, mem_req}, 32'd0);
    check_eq("t7_mem_addr", mem_addr, 32'd0);
    check_eq("t7_daok",     {31'd0, data_addr_ok}, 32'd0);
    check_eq("t7_perr",     {31'd0, protocol_err}, 32'd0);
    mem_data_ok = 1; #1;
    check_eq("t7_idok", {31'd0, inst_data_ok}, 32'd0);
    idle_inputs();
    cyc();
    resetn = 1;
    cyc(); cyc(); cyc();
    #1;
    check_eq("t7_post_req", {31'd0, mem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_sram_like_arbiter

`default_nettype wire
